// File: rtl/pinfilter_pkg.sv
// ============================================================================
// Module      : pinfilter_pkg
// Description : Shared constants and helpers for the pin filter bank.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pinfilter_pkg;

  // Pads idle high, so filters come out of reset reporting a released pin.
  localparam logic c_IDLE_LEVEL = 1'b1;

  function automatic int cnt_width(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage : pinfilter_pkg

`default_nettype wire

// File: rtl/pinfilter_chan.sv
// ============================================================================
// Module      : pinfilter_chan
// Description : One filtered pin: synchroniser, stability counter, edge bits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pinfilter_chan
  import pinfilter_pkg::*;
#(
  parameter int   DEPTH       = 2,
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = c_IDLE_LEVEL
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  input  logic ena,
  output logic dout,
  output logic rise,
  output logic fall
);

  localparam int               CNT_W     = cnt_width(DEPTH);
  localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_dout;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_s;

  assign w_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], din};
    end
  end

  // Edge bits clear every cycle so a strobe is one clock wide regardless of ena.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_dout <= RESET_VAL;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (ena) begin
        if (w_s == r_dout) begin
          r_cnt <= '0;
        end else if (r_cnt == c_CNT_MAX) begin
          r_cnt  <= '0;
          r_dout <= w_s;
          r_rise <= w_s;
          r_fall <= ~w_s;
        end else begin
          r_cnt <= r_cnt + c_CNT_ONE;
        end
      end
    end
  end

  assign dout = r_dout;
  assign rise = r_rise;
  assign fall = r_fall;

endmodule : pinfilter_chan

`default_nettype wire

// File: rtl/pinfilter_bank.sv
// ============================================================================
// Module      : pinfilter_bank
// Description : WIDTH independent deglitched GPIO inputs with edge strobes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pinfilter_bank
  import pinfilter_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               DEPTH       = 2,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] RESET_VAL   = {WIDTH{c_IDLE_LEVEL}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             ena,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             any_edge
);

  logic r_any_edge;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    pinfilter_chan #(
      .DEPTH       (DEPTH),
      .SYNC_STAGES (SYNC_STAGES),
      .RESET_VAL   (RESET_VAL[i])
    ) u_chan (
      .clk   (clk),
      .reset (reset),
      .din   (din[i]),
      .ena   (ena),
      .dout  (dout[i]),
      .rise  (rise[i]),
      .fall  (fall[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_any_edge <= 1'b0;
    end else begin
      r_any_edge <= |(rise | fall);
    end
  end

  assign any_edge = r_any_edge;

endmodule : pinfilter_bank

`default_nettype wire

// File: doc/pinfilter_bank.md
Name: pinfilter_bank

Overview:
- Parametrised, multi-channel successor to the single-pin GPIO deglitcher.
- Filters WIDTH asynchronous GPIO inputs with:
  - a SYNC_STAGES-deep synchroniser;
  - a per-channel stability counter, so an output changes only after DEPTH consecutive enabled samples disagree with it.
- Emits per-channel rise/fall strobes for downstream bus-interface logic. It sits between the GPIO pads and the cartridge/bus protocol decoders.

Parameters:
- WIDTH, 8, number of independent channels.
- DEPTH, 2, consecutive qualifying ena samples needed to change an output (1..256).
- SYNC_STAGES, 2, metastability flops per channel (>=2).
- RESET_VAL, {WIDTH{1'b1}}, per-channel value of synchroniser flops and dout after reset (idle-high pins).

Ports:
- clk  input  1  system clock; all logic is single-clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- din  input  WIDTH  raw asynchronous pin levels.
- ena  input  1  sample strobe; the filter state advances only on cycles with ena=1.
- dout  output  WIDTH  filtered levels.
- rise  output  WIDTH  one-cycle pulse when dout[i] goes 0->1.
- fall  output  WIDTH  one-cycle pulse when dout[i] goes 1->0.
- any_edge  output  1  registered OR of (rise|fall), one cycle after the pulse.

Behaviour:
- Reset (sampled on a clk edge with reset=1):
  - sync flops <= RESET_VAL;
  - cnt[i] <= 0;
  - dout <= RESET_VAL;
  - rise, fall, any_edge <= 0.
  - Reset dominates ena and din on the same cycle. Asserting reset mid-count discards the partial count.
- Synchroniser:
  - Shifts every clk, independent of ena.
  - s[i] is the last stage. din reaches s after SYNC_STAGES clocks.
- Counter: CNT_W = max(1, clog2(DEPTH)). On each cycle with ena=1, per channel:
  - If s[i]==dout[i]: cnt[i] <= 0.
  - If s[i]!=dout[i] and cnt[i]==DEPTH-1: dout[i] <= s[i], cnt[i] <= 0, and the matching rise[i]/fall[i] <= 1.
  - If s[i]!=dout[i] and cnt[i]<DEPTH-1: cnt[i] <= cnt[i]+1.
- DEPTH=1: dout follows s on every ena cycle with 1 ena of latency.
- Glitch rejection: any sample equal to dout before the count completes restarts the count. A pulse shorter than DEPTH ena samples never reaches dout.
- ena=0: cnt and dout hold; rise/fall <= 0. Pulses are exactly one clk wide even when ena is held high.
- Counter saturation: cnt never exceeds DEPTH-1, so no wrap-around.
- Latency: a clean din step reaches dout after SYNC_STAGES clocks plus DEPTH ena-qualified clocks (minimum SYNC_STAGES+DEPTH clocks when ena is tied high). rise/fall assert in the same cycle dout changes. any_edge asserts one cycle later.
- Channel independence: all channels are fully independent. Simultaneous transitions on several channels produce simultaneous strobes.
- No combinational path from din or ena to any output. All outputs are registered.

Decomposition:
- Shared header/package pinfilter_pkg:
  - clog2-based CNT_W helper function;
  - the default idle level constant.
- One natural sub-module: pinfilter_chan, one channel holding the synchroniser, counter, dout bit and edge bits. It is instantiated WIDTH times in a generate loop.
- The top level adds only the any_edge reduction register.

Test Plan:
- Reset values: WIDTH=8, RESET_VAL=8'hFF, din=8'h00, reset held 3 clk -> dout=8'hFF, rise=fall=0, any_edge=0 throughout reset.
- Clean step: DEPTH=2, SYNC_STAGES=2, ena=1, din[0] 1->0 at cycle 0 -> dout[0]=0 at cycle 4, fall[0]=1 for exactly cycle 4, any_edge=1 at cycle 5, other channels unchanged.
- Glitch rejection: DEPTH=4, ena=1, din[3] low for 3 clocks then high -> dout[3] stays 1, no fall pulse. Low for 4 clocks -> fall[3] pulses once.
- Ena gating: DEPTH=3, ena=1 one cycle in four, din[1] steps 1->0 -> dout[1] changes on the 3rd ena cycle after sync. Counts hold between strobes and strobes stay one clk wide.
- Reset mid-count: DEPTH=4, din[2] low for 2 ena samples, then reset one clk with din still low -> dout[2]=1 and the count restarts, fall[2] occurs 2+4 clocks after reset release.
- Multi-channel and DEPTH=1: din 8'hFF->8'h5A with ena=1 -> dout=8'h5A after 3 clocks, fall=8'hA5 in that cycle, rise=0. Returning to 8'hFF gives rise=8'hA5.
